// File: rtl/oai211_pkg.sv
// rtl/oai211_pkg.sv - shared constants and helper functions for the OAI211 pipeline
package oai211_pkg;

  // Widest channel count the helpers cover; callers extend their operands to this width.
  localparam int MAX_W = 256;

  // Width of a population count over MAX_W bits (clog2(MAX_W+1)).
  localparam int PC_MAX_W = 9;

  // Value of ZN for all-zero inputs; every data register resets to it.
  localparam logic [MAX_W-1:0] ZN_RST = '1;

  // Bitwise OAI211: ZN = ~((C1 | C2) & A & B).
  function automatic logic [MAX_W-1:0] oai211_f(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] c1,
    input logic [MAX_W-1:0] c2
  );
    return ~((c1 | c2) & a & b);
  endfunction

  // Number of set bits in v.
  function automatic logic [PC_MAX_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [PC_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + PC_MAX_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/oai211_stage.sv
// rtl/oai211_stage.sv - one data+valid pipeline register with advance enable and load-on-valid
module oai211_stage
  import oai211_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Valid follows the upstream stage on every advance; data only moves on a valid
  // beat, so a bubble leaves the last valid result in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= WIDTH'(ZN_RST);
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/oai211_pipe_xn.sv
// rtl/oai211_pipe_xn.sv - pipelined multi-channel OAI211 with valid tracking and toggle counter
module oai211_pipe_xn
  import oai211_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             CK,
  input  logic             R,
  input  logic             EN,
  input  logic             VALID_I,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C1,
  input  logic [WIDTH-1:0] C2,
  input  logic             CNT_CLR,
  output logic [WIDTH-1:0] ZN,
  output logic             VALID_O,
  output logic [CNT_W-1:0] TOGGLE_CNT
);

  // Popcount width for WIDTH bits, and a sum width that can never wrap even when
  // the popcount is wider than the counter itself.
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;

  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  // Index 0 is the combinational result; index k is the output of stage k.
  logic [WIDTH-1:0] w_data  [0:STAGES];
  logic             w_valid [0:STAGES];

  logic [WIDTH-1:0] w_zn_comb;
  logic [WIDTH-1:0] w_diff;
  logic [PC_W-1:0]  w_pc;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cnt_inc;

  logic [CNT_W-1:0] r_cnt;

  assign w_zn_comb = WIDTH'(oai211_f(MAX_W'(A), MAX_W'(B), MAX_W'(C1), MAX_W'(C2)));

  assign w_data[0]  = w_zn_comb;
  assign w_valid[0] = VALID_I;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    oai211_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk   (CK),
      .i_rst   (R),
      .i_en    (EN),
      .i_valid (w_valid[g]),
      .i_data  (w_data[g]),
      .o_valid (w_valid[g+1]),
      .o_data  (w_data[g+1])
    );
  end

  assign ZN      = w_data[STAGES];
  assign VALID_O = w_valid[STAGES];

  // The final stage reloads only when its incoming valid is set, so the bits that
  // flip are exactly those differing between the incoming beat and the current ZN.
  assign w_cnt_inc  = EN && w_valid[STAGES-1];
  assign w_diff     = w_data[STAGES-1] ^ w_data[STAGES];
  assign w_pc       = PC_W'(popcount(MAX_W'(w_diff)));
  assign w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pc);
  assign w_cnt_next = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(w_sum);

  // Saturating toggle counter; clear ignores EN and beats a same-edge increment.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      r_cnt <= '0;
    end else if (CNT_CLR) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= w_cnt_next;
    end
  end

  assign TOGGLE_CNT = r_cnt;

endmodule

// File: tb/tb_oai211_pipe_xn.sv
// tb/tb_oai211_pipe_xn.sv - self-checking bench for oai211_pipe_xn
module tb_oai211_pipe_xn;

  logic       CK;
  logic       R;
  logic       EN;
  logic       VALID_I;
  logic [7:0] A, B, C1, C2;
  logic       CNT_CLR;

  logic [7:0]  ZN, ZN2, ZN3;
  logic        VALID_O, VALID_O2, VALID_O3;
  logic [15:0] TOGGLE_CNT, TOGGLE_CNT3;
  logic [3:0]  TOGGLE_CNT2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       valid;
    logic [7:0] a, b, c1, c2;
    logic [7:0] exp_zn;
  } vec_t;

  vec_t vecs [10];

  oai211_pipe_xn #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
    .CK(CK), .R(R), .EN(EN), .VALID_I(VALID_I), .A(A), .B(B), .C1(C1), .C2(C2),
    .CNT_CLR(CNT_CLR), .ZN(ZN), .VALID_O(VALID_O), .TOGGLE_CNT(TOGGLE_CNT)
  );

  oai211_pipe_xn #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_sat (
    .CK(CK), .R(R), .EN(EN), .VALID_I(VALID_I), .A(A), .B(B), .C1(C1), .C2(C2),
    .CNT_CLR(CNT_CLR), .ZN(ZN2), .VALID_O(VALID_O2), .TOGGLE_CNT(TOGGLE_CNT2)
  );

  oai211_pipe_xn #(.WIDTH(8), .STAGES(1), .CNT_W(16)) dut_s1 (
    .CK(CK), .R(R), .EN(EN), .VALID_I(VALID_I), .A(A), .B(B), .C1(C1), .C2(C2),
    .CNT_CLR(CNT_CLR), .ZN(ZN3), .VALID_O(VALID_O3), .TOGGLE_CNT(TOGGLE_CNT3)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] exp_zn);
    VALID_I = v;
    A = a; B = b; C1 = c1; C2 = c2;
    if (v) exp_q.push_back(exp_zn);
  endtask

  // Scoreboard: each edge that advanced the pipe with a valid result pops one expectation.
  logic       mon_en, mon_r;
  logic [7:0] mon_exp;
  always @(posedge CK) begin
    mon_en = EN;
    mon_r  = R;
    #1;
    if (mon_en && !mon_r && VALID_O) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got VALID_O=1 with ZN=%0h, expected no beat", ZN);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_zn", {24'd0, ZN}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    logic [7:0] ra, rb, rc1, rc2;
    logic       rv;
    int         wait_cyc;

    R = 1'b1; EN = 1'b0; VALID_I = 1'b0; CNT_CLR = 1'b0;
    A = '0; B = '0; C1 = '0; C2 = '0;

    vecs[0] = '{1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00};
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 8'hAA, 8'hFF, 8'hFF, 8'h00, 8'h55};
    vecs[3] = '{1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    vecs[4] = '{1'b1, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 8'hF0, 8'hFF, 8'h00, 8'hF0, 8'h0F};
    vecs[6] = '{1'b1, 8'h3C, 8'hFF, 8'hC3, 8'h00, 8'hFF};
    vecs[7] = '{1'b1, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'hFF};
    vecs[8] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[9] = '{1'b1, 8'h81, 8'hFF, 8'h01, 8'h80, 8'h7E};

    // Reset state
    #12;
    check("rst_zn",    {24'd0, ZN}, 32'hFF);
    check("rst_valid", {31'd0, VALID_O}, 32'd0);
    check("rst_cnt",   {16'd0, TOGGLE_CNT}, 32'd0);
    step();
    R = 1'b0;

    // First beat: latency 2 (and 1 on the single-stage instance)
    EN = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    check("lat_early_valid", {31'd0, VALID_O}, 32'd0);
    check("s1_valid",        {31'd0, VALID_O3}, 32'd1);
    check("s1_zn",           {24'd0, ZN3}, 32'h00);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("lat_valid", {31'd0, VALID_O}, 32'd1);
    check("lat_zn",    {24'd0, ZN}, 32'h00);
    check("lat_cnt",   {16'd0, TOGGLE_CNT}, 32'd8);

    // Freeze with a result on ZN and another beat in flight
    drive(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF);
    step();
    drive(1'b1, 8'hAA, 8'hFF, 8'hFF, 8'h00, 8'h55);
    step();
    check("pre_frz_zn",  {24'd0, ZN}, 32'hFF);
    check("pre_frz_cnt", {16'd0, TOGGLE_CNT}, 32'd16);
    EN = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_zn",    {24'd0, ZN}, 32'hFF);
      check("frz_valid", {31'd0, VALID_O}, 32'd1);
      check("frz_cnt",   {16'd0, TOGGLE_CNT}, 32'd16);
    end
    EN = 1'b1;
    step();
    check("resume_zn",    {24'd0, ZN}, 32'h55);
    check("resume_valid", {31'd0, VALID_O}, 32'd1);
    check("resume_cnt",   {16'd0, TOGGLE_CNT}, 32'd20);
    step();
    check("drain_valid", {31'd0, VALID_O}, 32'd0);
    check("drain_zn",    {24'd0, ZN}, 32'h55);

    // Bubble between two valid beats
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    drive(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    step();
    check("bub_v1_cnt", {16'd0, TOGGLE_CNT}, 32'd24);
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    check("bub_valid", {31'd0, VALID_O}, 32'd0);
    check("bub_zn",    {24'd0, ZN}, 32'h00);
    check("bub_cnt",   {16'd0, TOGGLE_CNT}, 32'd24);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("bub_v2_valid", {31'd0, VALID_O}, 32'd1);
    check("bub_v2_cnt",   {16'd0, TOGGLE_CNT}, 32'd24);

    // Table-driven vectors, streamed back to back
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].c1, vecs[i].c2, vecs[i].exp_zn);
      step();
    end

    // Random beats with random bubbles
    for (int i = 0; i < 12; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rc1 = 8'($urandom_range(0, 255));
      rc2 = 8'($urandom_range(0, 255));
      rv  = 1'($urandom_range(0, 1));
      drive(rv, ra, rb, rc1, rc2, ~((rc1 | rc2) & ra & rb));
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    check("drain_q", exp_q.size(), 32'd0);

    // Asynchronous reset mid-cycle with ZN=00 and VALID_O=1
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("pre_rst_valid", {31'd0, VALID_O}, 32'd1);
    check("pre_rst_zn",    {24'd0, ZN}, 32'h00);
    #2;
    R = 1'b1;
    #1;
    check("arst_zn",    {24'd0, ZN}, 32'hFF);
    check("arst_valid", {31'd0, VALID_O}, 32'd0);
    check("arst_cnt",   {16'd0, TOGGLE_CNT}, 32'd0);
    exp_q.delete();
    step();
    R = 1'b0;

    // Saturation (CNT_W=4) and clear-beats-increment
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    drive(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF);
    step();
    check("sat1_zn",   {24'd0, ZN2}, 32'h00);
    check("sat1_cnt",  {28'd0, TOGGLE_CNT2}, 32'd8);
    check("wide1_cnt", {16'd0, TOGGLE_CNT}, 32'd8);
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    check("sat2_zn",   {24'd0, ZN2}, 32'hFF);
    check("sat2_cnt",  {28'd0, TOGGLE_CNT2}, 32'd15);
    check("wide2_cnt", {16'd0, TOGGLE_CNT}, 32'd16);
    drive(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF);
    step();
    check("sat3_cnt",  {28'd0, TOGGLE_CNT2}, 32'd15);
    check("wide3_cnt", {16'd0, TOGGLE_CNT}, 32'd24);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    check("clr_zn",       {24'd0, ZN2}, 32'hFF);
    check("clr_sat_cnt",  {28'd0, TOGGLE_CNT2}, 32'd0);
    check("clr_wide_cnt", {16'd0, TOGGLE_CNT}, 32'd0);

    // Clear while frozen
    drive(1'b1, 8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("pre_frzclr_cnt", {16'd0, TOGGLE_CNT}, 32'd8);
    EN = 1'b0;
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    check("frzclr_cnt", {16'd0, TOGGLE_CNT}, 32'd0);
    check("frzclr_zn",  {24'd0, ZN}, 32'h00);
    EN = 1'b1;
    step();
    step();
    check("end_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
